// File: rtl/core_c1_trap_ctrl.sv
// Machine-mode trap controller: takes traps and mret at the commit boundary and redirects fetch.
// Build option C1_TRAP_VECTORED_EN enables a writable mtvec MODE and vectored interrupt targets.
//
// state      | meaning
// IDLE       | watching the commit boundary for exception / interrupt / mret
// TRAP_REDIR | one-cycle redirect to the trap handler, trap_taken pulse
// MRET_REDIR | one-cycle redirect back to mepc
module core_c1_trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interrupt_in,
    input  logic [7:0]  interrupt_code_in,
    input  logic        exception_in,
    input  logic [7:0]  exception_code_in,
    input  logic [31:0] exception_tval_in,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_pc_in,
    input  logic        mret_in,
    input  logic        csr_wr_en,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        flush_out,
    output logic        redirect_valid_out,
    output logic [31:0] redirect_pc_out,
    output logic        trap_taken_out
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;

    typedef enum logic [1:0] {IDLE, TRAP_REDIR, MRET_REDIR} state_t;
    state_t state_q, state_d;

    logic        status_mie_q, status_mpie_q;
    logic [2:0]  mie_en_q;          // enables for codes 3, 7, 11
    logic [29:0] mtvec_base_q;
    logic [31:0] mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] mtvec_rd, trap_target;
    logic [2:0]  mip_bits;
    logic        int_en_sel, int_ok;
    logic        take_exc, take_int, take_mret, take_trap;

`ifdef C1_TRAP_VECTORED_EN
    logic mtvec_mode_q;
    assign mtvec_rd = {mtvec_base_q, 1'b0, mtvec_mode_q};
`else
    assign mtvec_rd = {mtvec_base_q, 2'b00};
`endif

    always_comb begin
        mip_bits   = 3'b000;
        int_en_sel = 1'b0;
        case (interrupt_code_in)
            8'd3:    begin mip_bits[0] = interrupt_in; int_en_sel = mie_en_q[0]; end
            8'd7:    begin mip_bits[1] = interrupt_in; int_en_sel = mie_en_q[1]; end
            8'd11:   begin mip_bits[2] = interrupt_in; int_en_sel = mie_en_q[2]; end
            default: ;
        endcase
    end

    assign int_ok    = interrupt_in & status_mie_q & int_en_sel;
    assign take_exc  = (state_q == IDLE) & instr_valid_in & exception_in;
    assign take_int  = (state_q == IDLE) & instr_valid_in & ~exception_in & int_ok;
    assign take_mret = (state_q == IDLE) & instr_valid_in & ~exception_in & ~int_ok & mret_in;
    assign take_trap = take_exc | take_int;
    assign flush_out = take_trap | take_mret;

    always_comb begin
        trap_target = {mtvec_base_q, 2'b00};
`ifdef C1_TRAP_VECTORED_EN
        if (take_int && mtvec_mode_q)
            trap_target = {mtvec_base_q, 2'b00} + {22'b0, interrupt_code_in, 2'b00};
`endif
    end

    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE) begin
            if (take_trap)
                state_d = TRAP_REDIR;
            else if (take_mret)
                state_d = MRET_REDIR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take_trap)
                redirect_pc_q <= trap_target;
            else if (take_mret)
                redirect_pc_q <= mepc_q;
        end
    end

    assign redirect_valid_out = (state_q != IDLE);
    assign trap_taken_out     = (state_q == TRAP_REDIR);
    assign redirect_pc_out    = redirect_pc_q;

    // CSR writes land first; trap/mret updates below override the fields they own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_en_q      <= 3'b000;
            mtvec_base_q  <= MTVEC_RESET[31:2];
`ifdef C1_TRAP_VECTORED_EN
            mtvec_mode_q  <= (MTVEC_RESET[1:0] == 2'b01);
`endif
            mscratch_q    <= 32'h0;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mtval_q       <= 32'h0;
        end else begin
            if (csr_wr_en) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        status_mie_q  <= csr_wdata[3];
                        status_mpie_q <= csr_wdata[7];
                    end
                    A_MIE:      mie_en_q <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
                    A_MTVEC: begin
                        mtvec_base_q <= csr_wdata[31:2];
`ifdef C1_TRAP_VECTORED_EN
                        mtvec_mode_q <= (csr_wdata[1:0] == 2'b01);
`endif
                    end
                    A_MSCRATCH: mscratch_q <= csr_wdata;
                    A_MEPC:     mepc_q     <= csr_wdata & 32'hFFFF_FFFC;
                    A_MCAUSE:   mcause_q   <= csr_wdata;
                    A_MTVAL:    mtval_q    <= csr_wdata;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc_q        <= instr_pc_in & 32'hFFFF_FFFC;
                mcause_q      <= take_exc ? {24'b0, exception_code_in}
                                          : {1'b1, 23'b0, interrupt_code_in};
                mtval_q       <= take_exc ? exception_tval_in : 32'h0;
                status_mpie_q <= status_mie_q;
                status_mie_q  <= 1'b0;
            end else if (take_mret) begin
                status_mie_q  <= status_mpie_q;
                status_mpie_q <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};
            A_MIE:      csr_rdata = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
            A_MTVEC:    csr_rdata = mtvec_rd;
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MTVAL:    csr_rdata = mtval_q;
            A_MIP:      csr_rdata = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
            default:    csr_rdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_core_c1_trap_ctrl.sv
// Directed bench for core_c1_trap_ctrl: traps, interrupt gating, priority, mret, vectoring, reset.
module tb_core_c1_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        interrupt_in;
    logic [7:0]  interrupt_code_in;
    logic        exception_in;
    logic [7:0]  exception_code_in;
    logic [31:0] exception_tval_in;
    logic        instr_valid_in;
    logic [31:0] instr_pc_in;
    logic        mret_in;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        trap_taken_out;

    int total = 0;
    int bad   = 0;

    core_c1_trap_ctrl #(.MTVEC_RESET(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .interrupt_in(interrupt_in), .interrupt_code_in(interrupt_code_in),
        .exception_in(exception_in), .exception_code_in(exception_code_in),
        .exception_tval_in(exception_tval_in),
        .instr_valid_in(instr_valid_in), .instr_pc_in(instr_pc_in), .mret_in(mret_in),
        .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .flush_out(flush_out), .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out), .trap_taken_out(trap_taken_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_wr_en = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_wr_en = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    // Drive a commit at the next negedge; comb outputs settle before the following posedge.
    task automatic commit(input logic v, input logic [31:0] pc, input logic exc,
                          input logic [7:0] ecode, input logic [31:0] tval,
                          input logic intr, input logic [7:0] icode, input logic mr);
        @(negedge clk);
        instr_valid_in = v; instr_pc_in = pc; exception_in = exc;
        exception_code_in = ecode; exception_tval_in = tval;
        interrupt_in = intr; interrupt_code_in = icode; mret_in = mr;
        #1;
    endtask

    task automatic quiet();
        @(negedge clk);
        instr_valid_in = 1'b0; exception_in = 1'b0; interrupt_in = 1'b0; mret_in = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        interrupt_in = 1'b0; interrupt_code_in = 8'd0;
        exception_in = 1'b0; exception_code_in = 8'd0; exception_tval_in = 32'h0;
        instr_valid_in = 1'b0; instr_pc_in = 32'h0; mret_in = 1'b0;
        csr_wr_en = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        #12;
        chk("rst_redir_valid", {31'b0, redirect_valid_out}, 32'h0);
        chk("rst_redir_pc", redirect_pc_out, 32'h0);
        chk("rst_trap_taken", {31'b0, trap_taken_out}, 32'h0);
        csr_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_chk("rst_mtvec", 12'h305, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exception with MIE=1
        csr_wr(12'h305, 32'h0000_0200);
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h340, 32'hCAFE_F00D);
        csr_chk("mscratch", 12'h340, 32'hCAFE_F00D);
        csr_chk("unmapped", 12'h7C0, 32'h0);
        commit(1'b1, 32'h100, 1'b1, 8'd2, 32'hDEAD, 1'b0, 8'd0, 1'b0);
        chk("exc_flush", {31'b0, flush_out}, 32'h1);
        after_edge();
        chk("exc_redir_valid", {31'b0, redirect_valid_out}, 32'h1);
        chk("exc_redir_pc", redirect_pc_out, 32'h200);
        chk("exc_trap_taken", {31'b0, trap_taken_out}, 32'h1);
        chk("exc_no_flush_in_redir", {31'b0, flush_out}, 32'h0);
        quiet();
        after_edge();
        chk("exc_pulse_end", {31'b0, redirect_valid_out}, 32'h0);
        csr_chk("exc_mepc", 12'h341, 32'h100);
        csr_chk("exc_mcause", 12'h342, 32'h2);
        csr_chk("exc_mtval", 12'h343, 32'hDEAD);
        csr_chk("exc_mstatus", 12'h300, 32'h0000_1880);

        // Interrupt 7 gated by mie[7]=0
        csr_wr(12'h300, 32'h0000_0008);
        commit(1'b1, 32'h104, 1'b0, 8'd0, 32'h0, 1'b1, 8'd7, 1'b0);
        chk("gated_flush", {31'b0, flush_out}, 32'h0);
        csr_chk("mip_7", 12'h344, 32'h80);
        after_edge();
        chk("gated_no_redir", {31'b0, redirect_valid_out}, 32'h0);
        quiet();
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_chk("mie_mask", 12'h304, 32'h888);
        csr_wr(12'h304, 32'h0000_0080);
        commit(1'b1, 32'h107, 1'b0, 8'd0, 32'h1234, 1'b1, 8'd7, 1'b0);
        chk("int_flush", {31'b0, flush_out}, 32'h1);
        after_edge();
        chk("int_redir_pc", redirect_pc_out, 32'h200);
        chk("int_trap_taken", {31'b0, trap_taken_out}, 32'h1);
        quiet();
        csr_chk("int_mcause", 12'h342, 32'h8000_0007);
        csr_chk("int_mtval", 12'h343, 32'h0);
        csr_chk("int_mepc", 12'h341, 32'h104);
        csr_chk("int_mstatus", 12'h300, 32'h0000_1880);

        // Exception + interrupt + mret on one commit: exception wins
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0888);
        commit(1'b1, 32'h300, 1'b1, 8'd11, 32'h55, 1'b1, 8'd3, 1'b1);
        chk("prio_flush", {31'b0, flush_out}, 32'h1);
        after_edge();
        chk("prio_trap_taken", {31'b0, trap_taken_out}, 32'h1);
        quiet();
        csr_chk("prio_mcause", 12'h342, 32'hB);
        csr_chk("prio_mtval", 12'h343, 32'h55);

        // mret back to mepc
        csr_wr(12'h341, 32'h140);
        csr_wr(12'h300, 32'h0000_0080);
        commit(1'b1, 32'h400, 1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1);
        chk("mret_flush", {31'b0, flush_out}, 32'h1);
        after_edge();
        chk("mret_redir_valid", {31'b0, redirect_valid_out}, 32'h1);
        chk("mret_redir_pc", redirect_pc_out, 32'h140);
        chk("mret_trap_taken", {31'b0, trap_taken_out}, 32'h0);
        quiet();
        csr_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        // MODE=2/3 writes store 0; then MODE=1
        csr_wr(12'h305, 32'h0000_0203);
        csr_chk("mtvec_mode3", 12'h305, 32'h200);
        csr_wr(12'h305, 32'h0000_0201);
`ifdef C1_TRAP_VECTORED_EN
        csr_chk("mtvec_mode1", 12'h305, 32'h201);
`else
        csr_chk("mtvec_mode1", 12'h305, 32'h200);
`endif
        // Pending interrupt 11 waits while no instruction commits
        commit(1'b0, 32'h500, 1'b0, 8'd0, 32'h0, 1'b1, 8'd11, 1'b0);
        chk("noval_flush", {31'b0, flush_out}, 32'h0);
        after_edge();
        chk("noval_no_redir", {31'b0, redirect_valid_out}, 32'h0);
        commit(1'b1, 32'h500, 1'b0, 8'd0, 32'h0, 1'b1, 8'd11, 1'b0);
        chk("vec_flush", {31'b0, flush_out}, 32'h1);
        after_edge();
`ifdef C1_TRAP_VECTORED_EN
        chk("vec_redir_pc", redirect_pc_out, 32'h22C);
`else
        chk("vec_redir_pc", redirect_pc_out, 32'h200);
`endif
        quiet();
        csr_chk("vec_mcause", 12'h342, 32'h8000_000B);

        // Exceptions target BASE even in vectored mode; reset during TRAP_REDIR
        csr_wr(12'h300, 32'h0000_0008);
        commit(1'b1, 32'h600, 1'b1, 8'd3, 32'h77, 1'b0, 8'd0, 1'b0);
        after_edge();
        chk("exc_vec_pc", redirect_pc_out, 32'h200);
        chk("pre_rst_redir", {31'b0, redirect_valid_out}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_redir_valid", {31'b0, redirect_valid_out}, 32'h0);
        chk("midrst_trap_taken", {31'b0, trap_taken_out}, 32'h0);
        chk("midrst_redir_pc", redirect_pc_out, 32'h0);
        csr_chk("midrst_mepc", 12'h341, 32'h0);
        csr_chk("midrst_mcause", 12'h342, 32'h0);
        csr_chk("midrst_mtval", 12'h343, 32'h0);
        csr_chk("midrst_mtvec", 12'h305, 32'h0);
        csr_chk("midrst_mstatus", 12'h300, 32'h0000_1800);
        csr_chk("midrst_mie", 12'h304, 32'h0);
        csr_chk("midrst_mscratch", 12'h340, 32'h0);
        quiet();
        rst_n = 1'b1;
        after_edge();
        chk("post_rst_idle", {31'b0, redirect_valid_out}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
